// File: rtl/rr_hold_arb_pkg.sv
// Shared helpers for the round-robin hold arbiter: priority-mask and counter-width
// functions plus the default burst length.
package rr_hold_arb_pkg;

    localparam int MAX_HOLD_DEFAULT = 4;

    // Widest requester vector the mask helper supports; callers truncate to N.
    localparam int MASK_MAXW = 256;

    function automatic int cnt_width(input int max_hold);
        return (max_hold + 1 > 2) ? $clog2(max_hold + 1) : 1;
    endfunction

    // Sets every bit above index k, so k and everything below it lose priority.
    function automatic logic [MASK_MAXW-1:0] next_mask(input logic [31:0] k);
        return ~((MASK_MAXW'(2) << k) - MASK_MAXW'(1));
    endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Combinational lowest-set-bit finder: one-hot winner, its binary index and an any-valid flag.
module rr_prio_enc #(
    parameter int N = 32
) (
    input  logic [N-1:0]                  req,
    output logic [N-1:0]                  onehot,
    output logic [(N > 1 ? $clog2(N) : 1)-1:0] idx,
    output logic                          any
);

    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    assign onehot = req & (~req + N'(1));
    assign any    = |req;

    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with a bounded grant-hold window and same-cycle grant.
// Optional owner lock input enabled by `define RR_HOLD_ARB_LOCK_EN.
module rr_hold_arbiter
    import rr_hold_arb_pkg::*;
#(
    parameter int N        = 32,
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [N-1:0]                        req_i,
`ifdef RR_HOLD_ARB_LOCK_EN
    input  logic                                lock_i,
`endif
    output logic [N-1:0]                        gnt_o,
    output logic                                gnt_vld_o,
    output logic [(N > 1 ? $clog2(N) : 1)-1:0]  gnt_idx_o
);

    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam int CNTW = cnt_width(MAX_HOLD);

    logic [N-1:0]    mask_q;
    logic [IDXW-1:0] owner_q;
    logic            owner_vld_q;
    logic [CNTW-1:0] hold_cnt_q;

    logic [N-1:0]    masked_req;
    logic [N-1:0]    m_onehot;
    logic [N-1:0]    u_onehot;
    logic [IDXW-1:0] m_idx;
    logic [IDXW-1:0] u_idx;
    logic            m_any;
    logic            u_any;

    logic [N-1:0]    win_onehot;
    logic [IDXW-1:0] win_idx;
    logic [N-1:0]    owner_onehot;
    logic            owner_req;
    logic            hold_ok;
    logic            lock_act;
    logic            hold_cont;

    assign masked_req = req_i & mask_q;

    rr_prio_enc #(.N(N)) u_enc_masked (
        .req    (masked_req),
        .onehot (m_onehot),
        .idx    (m_idx),
        .any    (m_any)
    );

    rr_prio_enc #(.N(N)) u_enc_unmasked (
        .req    (req_i),
        .onehot (u_onehot),
        .idx    (u_idx),
        .any    (u_any)
    );

    assign win_onehot   = m_any ? m_onehot : u_onehot;
    assign win_idx      = m_any ? m_idx : u_idx;
    assign owner_onehot = N'(1) << owner_q;
    assign owner_req    = owner_vld_q && req_i[owner_q];
    assign hold_ok      = hold_cnt_q < CNTW'(MAX_HOLD - 1);

`ifdef RR_HOLD_ARB_LOCK_EN
    assign lock_act = lock_i;
`else
    assign lock_act = 1'b0;
`endif

    // A locked owner never expires; its counter simply stops at the last hold value.
    assign hold_cont = owner_req && (hold_ok || lock_act);

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        if (!reset) begin
            if (hold_cont) begin
                gnt_o     = owner_onehot;
                gnt_idx_o = owner_q;
                gnt_vld_o = 1'b1;
            end else if (u_any) begin
                gnt_o     = win_onehot;
                gnt_idx_o = win_idx;
                gnt_vld_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q      <= '1;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            hold_cnt_q  <= '0;
        end else if (hold_cont) begin
            if (hold_ok) begin
                hold_cnt_q <= hold_cnt_q + CNTW'(1);
            end
        end else if (u_any) begin
            owner_q     <= win_idx;
            owner_vld_q <= 1'b1;
            hold_cnt_q  <= '0;
            mask_q      <= N'(next_mask(32'(win_idx)));
        end else begin
            owner_vld_q <= 1'b0;
            hold_cnt_q  <= '0;
        end
    end

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Scoreboard bench for rr_hold_arbiter (N=4, MAX_HOLD=2) against a circular-search model;
// exercises lock_i when RR_HOLD_ARB_LOCK_EN is defined.
module tb_rr_hold_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 2;

    typedef struct {
        logic [N-1:0] req;
        logic         rst;
        logic         lk;
        logic [N-1:0] gnt;
        logic         vld;
        logic [1:0]   idx;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req = '0;
    logic         lock = 1'b0;
    logic [N-1:0] gnt;
    logic         gnt_vld;
    logic [1:0]   gnt_idx;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: current holder (-1 = none), cycles it has held, last winner.
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = N - 1;

    always #5 clk = ~clk;

    rr_hold_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req),
`ifdef RR_HOLD_ARB_LOCK_EN
        .lock_i    (lock),
`endif
        .gnt_o     (gnt),
        .gnt_vld_o (gnt_vld),
        .gnt_idx_o (gnt_idx)
    );

    // Higher-level rule: keep the holder while it requests and its burst is unfinished
    // (or locked); otherwise search circularly starting just after the last winner.
    task automatic modelStep(input logic [N-1:0] r, input logic rs, input logic lk,
                             output logic [N-1:0] eg, output logic [1:0] ei);
        bit lock_eff;
        int win;
        bit found;
`ifdef RR_HOLD_ARB_LOCK_EN
        lock_eff = lk;
`else
        lock_eff = 1'b0;
`endif
        eg = '0;
        ei = '0;
        if (rs) begin
            m_owner = -1;
            m_held  = 0;
            m_last  = N - 1;
        end else if (m_owner >= 0 && r[m_owner] && (m_held < MAX_HOLD || lock_eff)) begin
            eg = N'(1) << m_owner;
            ei = 2'(m_owner);
            if (m_held < MAX_HOLD) m_held++;
        end else if (r != '0) begin
            win   = 0;
            found = 0;
            for (int s = 1; s <= N; s++) begin
                if (!found && r[(m_last + s) % N]) begin
                    win   = (m_last + s) % N;
                    found = 1;
                end
            end
            eg      = N'(1) << win;
            ei      = 2'(win);
            m_owner = win;
            m_held  = 1;
            m_last  = win;
        end else begin
            m_owner = -1;
            m_held  = 0;
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic rs, input logic lk);
        exp_t e;
        @(negedge clk);
        req   = r;
        reset = rs;
        lock  = lk;
        e.req = r;
        e.rst = rs;
        e.lk  = lk;
        modelStep(r, rs, lk, e.gnt, e.idx);
        e.vld = (e.gnt != '0);
        sb.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (gnt !== e.gnt) begin
            errors++;
            $display("[TB] FAIL gnt req=%b rst=%0b lock=%0b got=%b want=%b", e.req, e.rst, e.lk, gnt, e.gnt);
        end
        checks++;
        if (gnt_vld !== e.vld) begin
            errors++;
            $display("[TB] FAIL gnt_vld req=%b rst=%0b got=%0b want=%0b", e.req, e.rst, gnt_vld, e.vld);
        end
        checks++;
        if (gnt_idx !== e.idx) begin
            errors++;
            $display("[TB] FAIL gnt_idx req=%b rst=%0b got=%0d want=%0d", e.req, e.rst, gnt_idx, e.idx);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : stimulus
        int drain;
        logic [N-1:0] r;
        applyStimulus(4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b1111, 1'b1, 1'b0);

        // Constant full request: each port held for two cycles, then wrap.
        for (int i = 0; i < 9; i++) applyStimulus(4'b1111, 1'b0, 1'b0);

        // Owner dropping its request mid-burst hands over in the same cycle.
        applyStimulus(4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0011, 1'b0, 1'b0);
        applyStimulus(4'b0010, 1'b0, 1'b0);
        applyStimulus(4'b0011, 1'b0, 1'b0);
        applyStimulus(4'b0001, 1'b0, 1'b0);

        // Sole requester survives expiry without a bubble, then idle.
        for (int i = 0; i < 5; i++) applyStimulus(4'b0100, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0);

        // Reset pulse while index 2 holds restarts priority at index 0.
        applyStimulus(4'b0100, 1'b0, 1'b0);
        applyStimulus(4'b1111, 1'b1, 1'b0);
        applyStimulus(4'b1111, 1'b0, 1'b0);
        applyStimulus(4'b1111, 1'b0, 1'b0);
        applyStimulus(4'b1111, 1'b0, 1'b0);

`ifdef RR_HOLD_ARB_LOCK_EN
        applyStimulus(4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b1111, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(4'b1111, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(4'b1111, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 400; i++) begin
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r = r | 4'b1000;
            applyStimulus(r, ($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0));
        end

        drain = 0;
        while (sb.size() != 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        @(negedge clk);
        #4;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain pending=%0d want=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
